// File: rtl/pixie_pkg.sv
// pixie_pkg: definitions shared by the Pixie front end and the CDP1802
// DMA/interrupt responder.
//   SC_*          state codes driven on the SC bus
//   resp_state_e  responder machine-cycle owner (core, DMA, interrupt)
//   DISPLAY_BASE  default start of the display buffer in memory
package pixie_pkg;

  localparam logic [1:0] SC_FETCH = 2'b00;
  localparam logic [1:0] SC_EXEC  = 2'b01;
  localparam logic [1:0] SC_DMA   = 2'b10;
  localparam logic [1:0] SC_INT   = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_DMA = 2'd1,
    ST_INT = 2'd2
  } resp_state_e;

  localparam logic [15:0] DISPLAY_BASE = 16'h0900;

endpackage

// File: rtl/dma_pointer.sv
// dma_pointer: R0 DMA pointer and S2 burst counter.
//   clk, reset     bus clock, synchronous active-high reset
//   load/load_data core write into R0 (wins over increment)
//   inc            advance R0 by one, wrapping FFFF -> 0000
//   burst_start    first S2 cycle of a burst (counter <= 1)
//   burst_inc      another back-to-back S2 cycle
//   burst_clr      burst ended
//   r0             current pointer
//   r0_next        value R0 takes at the coming edge
//   burst          S2 cycles issued in the current burst
module dma_pointer #(
  parameter logic [15:0] R0_RESET = 16'h0000,
  parameter int unsigned BURST_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [15:0]        load_data,
  input  logic               inc,
  input  logic               burst_start,
  input  logic               burst_inc,
  input  logic               burst_clr,
  output logic [15:0]        r0,
  output logic [15:0]        r0_next,
  output logic [BURST_W-1:0] burst
);

  logic [15:0]        r0_q, r0_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  always_comb begin
    r0_d    = r0_q;
    burst_d = burst_q;
    if (load)     r0_d = load_data;
    else if (inc) r0_d = r0_q + 16'd1;
    if (burst_start)    burst_d = BURST_W'(1);
    else if (burst_inc) burst_d = burst_q + BURST_W'(1);
    else if (burst_clr) burst_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r0_q    <= R0_RESET;
      burst_q <= '0;
    end else begin
      r0_q    <= r0_d;
      burst_q <= burst_d;
    end
  end

  assign r0      = r0_q;
  assign r0_next = r0_d;
  assign burst   = burst_q;

endmodule

// File: rtl/cdp1802_dma_int_responder.sv
// cdp1802_dma_int_responder: arbitrates CDP1802 machine cycles between the
// core (RUN), Pixie DMA-out (S2) and the frame interrupt (S3). Owns R0 and
// performs one memory read per S2 cycle, handing the byte to the display.
//   clk, reset        bus clock, synchronous active-high reset
//   clk_enable        machine-cycle tick; state moves only on ticks
//   core_sc           SC the core drives while it owns the cycle
//   core_cycle_done   core S1 ends at this tick (arbitration point)
//   core_idle         core in IDL; arbitrate at every tick
//   ie                core interrupt enable
//   dma_out_n         DMA-out request (active low)
//   int_req           interrupt request
//   r0_wr, r0_wdata   core write to R0 (only while the core runs)
//   mem_data          read data, valid at the tick ending S2
//   sc, core_hold     bus state code and core freeze
//   mem_addr, mem_rd  DMA read address (R0 during S2, else 0) and strobe
//   dma_data          last fetched byte, dma_strobe one-clk update pulse
//   int_ack           one-clk pulse on S3 entry
//   r0                current DMA pointer
module cdp1802_dma_int_responder
  import pixie_pkg::*;
#(
  parameter logic [15:0] R0_RESET  = 16'h0000,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [1:0]  core_sc,
  input  logic        core_cycle_done,
  input  logic        core_idle,
  input  logic        ie,
  input  logic        dma_out_n,
  input  logic        int_req,
  input  logic        r0_wr,
  input  logic [15:0] r0_wdata,
  input  logic [7:0]  mem_data,
  output logic [1:0]  sc,
  output logic        core_hold,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [7:0]  dma_data,
  output logic        dma_strobe,
  output logic        int_ack,
  output logic [15:0] r0
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  resp_state_e        state_q, state_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic               mem_rd_q, mem_rd_d;
  logic [7:0]         dma_data_q, dma_data_d;
  logic               dma_strobe_q, dma_strobe_d;
  logic               int_ack_q, int_ack_d;

  logic [15:0]        r0_next;
  logic [BURST_W-1:0] burst;
  logic               arb_ok, dma_tick, r0_load;

  assign arb_ok   = clk_enable && (state_q == ST_RUN) && (core_cycle_done || core_idle);
  assign dma_tick = clk_enable && (state_q == ST_DMA);
  // The core only writes R0 while it owns the cycle; the write lands before
  // arbitration so a DMA entering on the same tick reads the new address.
  assign r0_load  = clk_enable && (state_q == ST_RUN) && r0_wr;

  dma_pointer #(
    .R0_RESET (R0_RESET),
    .BURST_W  (BURST_W)
  ) u_ptr (
    .clk         (clk),
    .reset       (reset),
    .load        (r0_load),
    .load_data   (r0_wdata),
    .inc         (dma_tick),
    .burst_start (arb_ok && (state_d == ST_DMA)),
    .burst_inc   (dma_tick && (state_d == ST_DMA)),
    .burst_clr   (dma_tick && (state_d != ST_DMA)),
    .r0          (r0),
    .r0_next     (r0_next),
    .burst       (burst)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (clk_enable) begin
      unique case (state_q)
        ST_RUN: begin
          if (arb_ok) begin
            if (!dma_out_n)         state_d = ST_DMA;
            else if (int_req && ie) state_d = ST_INT;
          end
        end
        ST_DMA: begin
          // Burst cap forces one non-DMA cycle so the core keeps making progress.
          if (!dma_out_n && (burst < BURST_W'(MAX_BURST))) state_d = ST_DMA;
          else if (int_req && ie)                           state_d = ST_INT;
          else                                              state_d = ST_RUN;
        end
        ST_INT:  state_d = ST_RUN;
        default: state_d = ST_RUN;
      endcase
    end

    mem_rd_d     = (state_d == ST_DMA);
    mem_addr_d   = (state_d == ST_DMA) ? r0_next : 16'h0000;
    dma_data_d   = dma_tick ? mem_data : dma_data_q;
    dma_strobe_d = dma_tick;
    int_ack_d    = clk_enable && (state_q != ST_INT) && (state_d == ST_INT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset on every register here; reset wins over a tick,
    // so an in-flight S2 ends with no strobe and no pointer increment.
    if (reset) begin
      state_q      <= ST_RUN;
      mem_addr_q   <= 16'h0000;
      mem_rd_q     <= 1'b0;
      dma_data_q   <= 8'h00;
      dma_strobe_q <= 1'b0;
      int_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_q     <= mem_rd_d;
      dma_data_q   <= dma_data_d;
      dma_strobe_q <= dma_strobe_d;
      int_ack_q    <= int_ack_d;
    end
  end

  always_comb begin
    sc = core_sc;
    if (state_q == ST_DMA)      sc = SC_DMA;
    else if (state_q == ST_INT) sc = SC_INT;
  end

  assign core_hold  = (state_q != ST_RUN);
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign dma_data   = dma_data_q;
  assign dma_strobe = dma_strobe_q;
  assign int_ack    = int_ack_q;

endmodule

// File: tb/tb_cdp1802_dma_int_responder.sv
module tb_cdp1802_dma_int_responder;
  import pixie_pkg::*;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        reset, clk_enable, core_cycle_done, core_idle, ie, dma_out_n, int_req, r0_wr;
  logic [1:0]  core_sc;
  logic [15:0] r0_wdata;
  logic [7:0]  mem_data;
  logic [1:0]  sc;
  logic        core_hold, mem_rd, dma_strobe, int_ack;
  logic [15:0] mem_addr, r0;
  logic [7:0]  dma_data;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  cdp1802_dma_int_responder #(
    .R0_RESET  (DISPLAY_BASE),
    .MAX_BURST (MAXB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .core_sc         (core_sc),
    .core_cycle_done (core_cycle_done),
    .core_idle       (core_idle),
    .ie              (ie),
    .dma_out_n       (dma_out_n),
    .int_req         (int_req),
    .r0_wr           (r0_wr),
    .r0_wdata        (r0_wdata),
    .mem_data        (mem_data),
    .sc              (sc),
    .core_hold       (core_hold),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .dma_data        (dma_data),
    .dma_strobe      (dma_strobe),
    .int_ack         (int_ack),
    .r0              (r0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: who owns the current machine cycle, how long the
  // current DMA run has been, and what the display side has seen.
  bit          m_in_s2, m_in_s3;
  int          m_run_len;
  logic [15:0] m_r0;
  logic [7:0]  m_data;
  bit          m_strobe, m_ack;

  always @(posedge clk) begin
    if (reset) begin
      m_in_s2 = 0; m_in_s3 = 0; m_run_len = 0;
      m_r0 = DISPLAY_BASE; m_data = 8'h00; m_strobe = 0; m_ack = 0;
    end else begin
      m_strobe = 0;
      m_ack    = 0;
      if (clk_enable) begin
        if (m_in_s3) begin
          m_in_s3 = 0;
        end else if (m_in_s2) begin
          m_data   = mem_data;
          m_strobe = 1;
          m_r0     = m_r0 + 16'd1;
          if (!dma_out_n && m_run_len < MAXB) begin
            m_run_len++;
          end else begin
            m_in_s2   = 0;
            m_run_len = 0;
            if (int_req && ie) begin m_in_s3 = 1; m_ack = 1; end
          end
        end else begin
          if (r0_wr) m_r0 = r0_wdata;
          if (core_cycle_done || core_idle) begin
            if (!dma_out_n) begin
              m_in_s2 = 1; m_run_len = 1;
            end else if (int_req && ie) begin
              m_in_s3 = 1; m_ack = 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("sc", 32'(sc), 32'(m_in_s2 ? SC_DMA : (m_in_s3 ? SC_INT : core_sc)));
      check("core_hold", 32'(core_hold), 32'(m_in_s2 || m_in_s3));
      check("mem_addr", 32'(mem_addr), 32'(m_in_s2 ? m_r0 : 16'h0000));
      check("mem_rd", 32'(mem_rd), 32'(m_in_s2));
      check("dma_data", 32'(dma_data), 32'(m_data));
      check("dma_strobe", 32'(dma_strobe), 32'(m_strobe));
      check("int_ack", 32'(int_ack), 32'(m_ack));
      check("r0", 32'(r0), 32'(m_r0));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int s2cnt, strobes, s3cnt;
    reset = 1; clk_enable = 1; core_sc = SC_FETCH; core_cycle_done = 1; core_idle = 0;
    ie = 0; dma_out_n = 1; int_req = 0; r0_wr = 0; r0_wdata = 16'h0000; mem_data = 8'h00;
    step(); step();
    cmp_en = 1;
    check("rst_r0", 32'(r0), 32'h0900);
    check("rst_sc", 32'(sc), 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_dma_data", 32'(dma_data), 32'h00);
    reset = 0;
    step();

    // Single DMA cycle.
    dma_out_n = 0; step();
    check("single_sc", 32'(sc), 32'h2);
    check("single_addr", 32'(mem_addr), 32'h0900);
    dma_out_n = 1; mem_data = 8'hA5; step();
    check("single_strobe", 32'(dma_strobe), 32'h1);
    check("single_data", 32'(dma_data), 32'hA5);
    check("single_r0", 32'(r0), 32'h0901);
    step();
    check("single_strobe_off", 32'(dma_strobe), 32'h0);

    // Burst of 8, one forced RUN cycle, then S2 resumes.
    dma_out_n = 0; s2cnt = 0; strobes = 0;
    for (int i = 1; i <= 11; i++) begin
      mem_data = 8'(i);
      step();
      if (i <= 8 && sc == SC_DMA) s2cnt++;
      if (dma_strobe) strobes++;
      if (i == 9)  check("burst_gap", 32'(sc), 32'h0);
      if (i == 10) check("burst_resume", 32'(sc), 32'h2);
      if (i == 11) check("burst_r0", 32'(r0), 32'h090A);
    end
    check("burst_len", 32'(s2cnt), 32'd8);
    check("burst_strobes", 32'(strobes), 32'd9);
    dma_out_n = 1; step(); step();

    // DMA beats interrupt; S3 follows, then RUN without re-arbitration.
    dma_out_n = 0; int_req = 1; ie = 1; step();
    check("prio_dma", 32'(sc), 32'h2);
    dma_out_n = 1; step();
    check("prio_int_sc", 32'(sc), 32'h3);
    check("prio_int_ack", 32'(int_ack), 32'h1);
    step();
    check("prio_run", 32'(sc), 32'h0);
    check("prio_ack_off", 32'(int_ack), 32'h0);
    ie = 0;

    // Masked interrupt.
    s3cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sc == SC_INT || int_ack) s3cnt++;
    end
    check("masked", 32'(s3cnt), 32'd0);
    int_req = 0;

    // Write FFFF on the arbitration tick, DMA wraps, write during S2 ignored.
    r0_wr = 1; r0_wdata = 16'hFFFF; dma_out_n = 0; step();
    check("wrap_addr", 32'(mem_addr), 32'hFFFF);
    r0_wdata = 16'h1234; dma_out_n = 1; step();
    check("wrap_r0", 32'(r0), 32'h0000);
    r0_wr = 0; step();
    check("wrap_hold", 32'(r0), 32'h0000);

    // No tick: nothing moves.
    clk_enable = 0; dma_out_n = 0;
    step(); step(); step();
    check("no_tick", 32'(sc), 32'h0);
    clk_enable = 1;

    // Reset in the middle of S2.
    step();
    check("mid_s2", 32'(mem_rd), 32'h1);
    reset = 1; dma_out_n = 1; step();
    check("rst_s2_rd", 32'(mem_rd), 32'h0);
    check("rst_s2_strobe", 32'(dma_strobe), 32'h0);
    check("rst_s2_r0", 32'(r0), 32'h0900);
    check("rst_s2_addr", 32'(mem_addr), 32'h0000);
    reset = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      clk_enable      = ($urandom_range(0, 9) < 6);
      core_sc         = 2'($urandom_range(0, 1));
      core_cycle_done = $urandom_range(0, 1) == 1;
      core_idle       = $urandom_range(0, 9) == 0;
      dma_out_n       = $urandom_range(0, 9) >= 6;
      int_req         = $urandom_range(0, 9) < 3;
      ie              = $urandom_range(0, 1) == 1;
      r0_wr           = $urandom_range(0, 9) == 0;
      r0_wdata        = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      mem_data        = 8'($urandom);
      reset           = $urandom_range(0, 199) == 0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
